snoop_responder: RTL and testbench

Per-processor snoop side of the MESI bus protocol: watches transactions other processors broadcast on the shared 16-bit bus and answers them on behalf of one local cache. It looks up the snooped tag, downgrades or invalidates the local line, and writes back Modified data to data memory. It then offers the block to the requester over the has_block/block lines. One instance sits beside each processor, between the bus arbiter output and the processor's cache array.

---
 rtl/snoop_responder_if.sv | 40 ++++
 rtl/snoop_responder.sv | 190 +++++++++++++++++++
 tb/tb_snoop_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snoop_responder_if.sv
// snoop_responder_if: bus, cache-array and write-back signals between one
// snoop responder and its surroundings (bus arbiter, local cache array,
// data memory).
// Handshake rules:
//   - bus_valid qualifies bus for one cycle. It is only acted on while
//     snoop_busy is low; the arbiter holds the next word while snoop_busy is high.
//   - wb_req stays high with wb_block stable until the cycle in which wb_ack
//     is high. That cycle completes the transfer.
//   - upd_en, has_block and done are single-cycle strobes with no back-pressure.
interface snoop_responder_if;
   logic        bus_valid;
   logic [15:0] bus;
   logic        snoop_busy;
   logic [3:0]  lkp_tag;
   logic        lkp_hit;
   logic [15:0] lkp_line;
   logic        upd_en;
   logic [1:0]  upd_state;
   logic        wb_req;
   logic [15:0] wb_block;
   logic        wb_ack;
   logic        has_block;
   logic [15:0] block_out;
   logic        done;
   logic        err;

   // Responder side
   modport slave (
      input  bus_valid, bus, lkp_hit, lkp_line, wb_ack,
      output snoop_busy, lkp_tag, upd_en, upd_state, wb_req, wb_block,
             has_block, block_out, done, err
   );

   // Environment side: arbiter, cache array and memory
   modport master (
      output bus_valid, bus, lkp_hit, lkp_line, wb_ack,
      input  snoop_busy, lkp_tag, upd_en, upd_state, wb_req, wb_block,
             has_block, block_out, done, err
   );
endinterface

// File: rtl/snoop_responder.sv
// snoop_responder: MESI snoop side for one processor. It looks up snooped
// tags in the local cache, downgrades or invalidates the local line, writes
// back Modified data, and supplies the block to the requester.
// Optional feature macro: SNOOP_WB_TIMEOUT_EN. When it is defined, the
// write-back is aborted after WB_TIMEOUT cycles without wb_ack.
module snoop_responder #(
   parameter logic [1:0] PROC_ID = 2'b00
`ifdef SNOOP_WB_TIMEOUT_EN
   , parameter int unsigned WB_TIMEOUT = 15
`endif
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   snoop_responder_if.slave        sif,
   output logic [2:0]              o_dbg_state
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_EVAL   = 3'd2,
      S_WB     = 3'd3,
      S_SUPPLY = 3'd4
   } state_t;

   localparam logic [1:0] ST_I    = 2'b00;
   localparam logic [1:0] ST_S    = 2'b01;
   localparam logic [1:0] ST_M    = 2'b11;
   localparam logic [1:0] MSG_RD  = 2'b00;
   localparam logic [1:0] MSG_WR  = 2'b01;
   localparam logic [1:0] MSG_RSV = 2'b11;

   state_t      r_state, w_next;
   logic [1:0]  r_msg;
   logic [3:0]  r_tag;
   logic [1:0]  r_final;
   logic [3:0]  r_line_tag;
   logic [9:0]  r_data;
   logic [15:0] r_wb_block;
   logic        r_wb_fin;   // write-back finished (ack or timeout); next cycle updates the line
   logic        r_wb_to;    // write-back ended by timeout: skip the supply step
   logic        r_err;

   logic        w_capture, w_inv_err, w_wb_fin_set, w_wb_to_set;
   logic        w_upd_en, w_has_block, w_done;
   logic [1:0]  w_upd_state, w_line_st, w_final_eval;
   logic [15:0] w_block_out;
   logic        w_miss, w_eval_m_fill;
   logic [7:0]  w_unused_bus;

   assign w_line_st     = sif.lkp_line[11:10];
   assign w_miss        = !sif.lkp_hit || (w_line_st == ST_I);
   assign w_final_eval  = (r_msg == MSG_RD) ? ST_S : ST_I;
   assign w_eval_m_fill = (r_state == S_EVAL) && !w_miss && (w_line_st == ST_M) &&
                          ((r_msg == MSG_RD) || (r_msg == MSG_WR));
   assign w_unused_bus  = sif.bus[7:0];

`ifdef SNOOP_WB_TIMEOUT_EN
   localparam logic [3:0] LP_TO_LAST = 4'(WB_TIMEOUT - 1);
   logic [3:0] r_cnt;

   // Count write-back cycles spent waiting for wb_ack
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                            r_cnt <= '0;
      else if (r_state == S_EVAL)              r_cnt <= '0;
      else if (r_state == S_WB && !r_wb_fin)   r_cnt <= r_cnt + 4'd1;
   end
`endif

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state decode and strobe outputs
   always_comb begin
      w_next       = r_state;
      w_capture    = 1'b0;
      w_inv_err    = 1'b0;
      w_wb_fin_set = 1'b0;
      w_wb_to_set  = 1'b0;
      w_upd_en     = 1'b0;
      w_upd_state  = ST_I;
      w_has_block  = 1'b0;
      w_block_out  = '0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sif.bus_valid && (sif.bus[15:14] != PROC_ID) && (sif.bus[13:12] != MSG_RSV)) begin
               w_capture = 1'b1;
               w_next    = S_LOOKUP;
            end
         end
         S_LOOKUP: w_next = S_EVAL;
         S_EVAL: begin
            if (w_miss) begin
               w_done = 1'b1;
               w_next = S_IDLE;
            end else if ((r_msg == MSG_RD) || (r_msg == MSG_WR)) begin
               if (w_line_st == ST_M) begin
                  w_next = S_WB;
               end else begin
                  w_upd_en    = 1'b1;
                  w_upd_state = w_final_eval;
                  w_next      = S_SUPPLY;
               end
            end else begin
               // Invalidate: only a Shared copy may legally exist elsewhere
               if (w_line_st == ST_S) begin
                  w_upd_en    = 1'b1;
                  w_upd_state = ST_I;
               end else begin
                  w_inv_err = 1'b1;
               end
               w_done = 1'b1;
               w_next = S_IDLE;
            end
         end
         S_WB: begin
            if (r_wb_fin) begin
               w_upd_en    = 1'b1;
               w_upd_state = r_final;
               if (r_wb_to) begin
                  w_done = 1'b1;
                  w_next = S_IDLE;
               end else begin
                  w_next = S_SUPPLY;
               end
            end else if (sif.wb_ack) begin
               w_wb_fin_set = 1'b1;
`ifdef SNOOP_WB_TIMEOUT_EN
            end else if (r_cnt == LP_TO_LAST) begin
               w_wb_fin_set = 1'b1;
               w_wb_to_set  = 1'b1;
`endif
            end
         end
         S_SUPPLY: begin
            w_has_block = 1'b1;
            w_block_out = {r_line_tag, r_final, r_data};
            w_done      = 1'b1;
            w_next      = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Capture the snooped request, the looked-up line and write-back progress
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_msg      <= '0;
         r_tag      <= '0;
         r_final    <= '0;
         r_line_tag <= '0;
         r_data     <= '0;
         r_wb_block <= '0;
         r_wb_fin   <= 1'b0;
         r_wb_to    <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_capture) begin
            r_msg <= sif.bus[13:12];
            r_tag <= sif.bus[11:8];
         end
         if (r_state == S_EVAL) begin
            r_final    <= w_final_eval;
            r_line_tag <= sif.lkp_line[15:12];
            r_data     <= sif.lkp_line[9:0];
            r_wb_fin   <= 1'b0;
            r_wb_to    <= 1'b0;
         end
         if (w_eval_m_fill) r_wb_block <= sif.lkp_line;
         if (w_wb_fin_set)  r_wb_fin   <= 1'b1;
         if (w_wb_to_set)   r_wb_to    <= 1'b1;
         if (w_inv_err || w_wb_to_set) r_err <= 1'b1;
      end
   end

   assign sif.snoop_busy = (r_state != S_IDLE);
   assign sif.lkp_tag    = r_tag;
   assign sif.upd_en     = w_upd_en;
   assign sif.upd_state  = w_upd_state;
   assign sif.wb_req     = (r_state == S_WB) && !r_wb_fin;
   assign sif.wb_block   = r_wb_block;
   assign sif.has_block  = w_has_block;
   assign sif.block_out  = w_block_out;
   assign sif.done       = w_done;
   assign sif.err        = r_err;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_snoop_responder.sv
// tb_snoop_responder: cycle-exact scenario bench for snoop_responder
// (PROC_ID = 0). The per-cycle output vector is
// {snoop_busy, upd_en, upd_state[1:0], wb_req, has_block, done}.
`timescale 1ns/1ps
module tb_snoop_responder;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   snoop_responder_if sif();
   logic [2:0]  dbg_state;
   logic [15:0] line;
   logic        line_vld;

   // Local cache array model: a single resident line
   assign sif.lkp_hit  = line_vld && (sif.lkp_tag == line[15:12]);
   assign sif.lkp_line = line;

   snoop_responder #(.PROC_ID(2'b00)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .sif         (sif.slave),
      .o_dbg_state (dbg_state)
   );

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];     // expected block_out values
   logic [15:0] wb_exp_q[$];  // expected wb_block values

   // ---------------- driver tasks ----------------
   task automatic drive_snoop(input logic [1:0] req, input logic [1:0] msg, input logic [3:0] tag);
      @(posedge clk);
      #1;
      sif.bus_valid = 1'b1;
      sif.bus = {req, msg, tag, 8'($urandom_range(255, 0))};
      @(posedge clk);  // capture edge (cycle 0)
      #1;
      sif.bus_valid = 1'b0;
      sif.bus = 16'($urandom_range(65535, 0));
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [46:0] v;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      v = {sif.snoop_busy, sif.lkp_tag, sif.upd_en, sif.upd_state, sif.wb_req, sif.wb_block,
           sif.has_block, sif.block_out, sif.done, sif.err, dbg_state};
      checks++;
      if (v !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", v); end
      rst_n = 1'b1;
   endtask

   task automatic test_read_hit_e();
      logic [6:0] exp_tbl [4];
      logic [6:0] obs;
      logic [15:0] e;
      exp_tbl = '{7'b1000000, 7'b1101000, 7'b1000011, 7'b0000000};
      line = {4'hA, 2'b10, 10'h05A};
      line_vld = 1'b1;
      exp_q.push_back({4'hA, 2'b01, 10'h05A});
      drive_snoop(2'b01, 2'b00, 4'hA);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== exp_tbl[c]) begin failures++; $display("FAIL read_e cycle%0d: got %b want %b", c + 1, obs, exp_tbl[c]); end
         if (c == 0) begin
            checks++;
            if (sif.lkp_tag !== 4'hA) begin failures++; $display("FAIL read_e lkp_tag: got %h want a", sif.lkp_tag); end
         end
         if (sif.has_block) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if (sif.block_out !== e) begin failures++; $display("FAIL read_e block_out: got %h want %h", sif.block_out, e); end
         end
      end
   endtask

   task automatic test_write_hit_m();
      logic [6:0] exp_tbl [8];
      logic [6:0] obs;
      logic [15:0] e;
      logic prev_wb = 1'b0;
      exp_tbl = '{7'b1000000, 7'b1000000, 7'b1000100, 7'b1000100, 7'b1000100,
                  7'b1100000, 7'b1000011, 7'b0000000};
      line = {4'hC, 2'b11, 10'h3FF};
      line_vld = 1'b1;
      wb_exp_q.push_back({4'hC, 2'b11, 10'h3FF});
      exp_q.push_back({4'hC, 2'b00, 10'h3FF});
      drive_snoop(2'b10, 2'b01, 4'hC);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         sif.wb_ack = (c == 4);  // ack in cycle 5, two cycles after wb_req rises
         #1;
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== exp_tbl[c]) begin failures++; $display("FAIL write_m cycle%0d: got %b want %b", c + 1, obs, exp_tbl[c]); end
         if (sif.wb_req && !prev_wb) begin
            checks++;
            e = (wb_exp_q.size() > 0) ? wb_exp_q.pop_front() : 16'hxxxx;
            if (sif.wb_block !== e) begin failures++; $display("FAIL write_m wb_block: got %h want %h", sif.wb_block, e); end
         end
         prev_wb = sif.wb_req;
         if (sif.has_block) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if (sif.block_out !== e) begin failures++; $display("FAIL write_m block_out: got %h want %h", sif.block_out, e); end
         end
      end
      sif.wb_ack = 1'b0;
   endtask

   task automatic test_m_ack_early();
      logic [6:0] exp_tbl [6];
      logic [6:0] obs;
      logic [15:0] e;
      logic prev_wb = 1'b0;
      exp_tbl = '{7'b1000000, 7'b1000000, 7'b1000100, 7'b1101000, 7'b1000011, 7'b0000000};
      line = {4'h3, 2'b11, 10'h155};
      line_vld = 1'b1;
      wb_exp_q.push_back({4'h3, 2'b11, 10'h155});
      exp_q.push_back({4'h3, 2'b01, 10'h155});
      drive_snoop(2'b01, 2'b00, 4'h3);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         sif.wb_ack = (c == 1) || (c == 2);  // already high when WB is entered
         #1;
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== exp_tbl[c]) begin failures++; $display("FAIL ack_early cycle%0d: got %b want %b", c + 1, obs, exp_tbl[c]); end
         if (sif.wb_req && !prev_wb) begin
            checks++;
            e = (wb_exp_q.size() > 0) ? wb_exp_q.pop_front() : 16'hxxxx;
            if (sif.wb_block !== e) begin failures++; $display("FAIL ack_early wb_block: got %h want %h", sif.wb_block, e); end
         end
         prev_wb = sif.wb_req;
         if (sif.has_block) begin
            checks++;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            if (sif.block_out !== e) begin failures++; $display("FAIL ack_early block_out: got %h want %h", sif.block_out, e); end
         end
      end
      sif.wb_ack = 1'b0;
   endtask

   task automatic test_ignored();
      logic [6:0] obs;
      line = {4'hA, 2'b10, 10'h05A};
      line_vld = 1'b1;
      for (int k = 0; k < 2; k++) begin
         // k=0: own processor id; k=1: reserved message from P1
         if (k == 0) drive_snoop(2'b00, 2'b00, 4'hA);
         else        drive_snoop(2'b01, 2'b11, 4'hA);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
            checks++;
            if (obs !== 7'b0000000) begin failures++; $display("FAIL ignored%0d cycle%0d: got %b want 0000000", k, c + 1, obs); end
         end
      end
   endtask

   task automatic test_miss();
      logic [6:0] exp_tbl [3];
      logic [6:0] obs;
      exp_tbl = '{7'b1000000, 7'b1000001, 7'b0000000};
      for (int k = 0; k < 2; k++) begin
         // k=0: tag not present; k=1: line present but Invalid
         if (k == 0) begin line = {4'hA, 2'b10, 10'h05A}; drive_snoop(2'b01, 2'b00, 4'h7); end
         else        begin line = {4'h5, 2'b00, 10'h0AB}; drive_snoop(2'b10, 2'b01, 4'h5); end
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
            checks++;
            if (obs !== exp_tbl[c]) begin failures++; $display("FAIL miss%0d cycle%0d: got %b want %b", k, c + 1, obs, exp_tbl[c]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp_tbl [6];
      logic [6:0] obs;
      exp_tbl = '{7'b1000000, 7'b1000001, 7'b0000000, 7'b1000000, 7'b1000001, 7'b0000000};
      line = {4'hA, 2'b10, 10'h05A};
      @(posedge clk);
      #1;
      sif.bus_valid = 1'b1;  // held high: words during LOOKUP/EVAL must be ignored
      sif.bus = {2'b01, 2'b00, 4'h7, 8'h00};
      @(posedge clk);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (c == 4) sif.bus_valid = 1'b0;
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== exp_tbl[c]) begin failures++; $display("FAIL b2b cycle%0d: got %b want %b", c + 1, obs, exp_tbl[c]); end
      end
   endtask

   task automatic test_invalidate();
      logic [6:0] exp_tbl [3];
      logic [6:0] obs;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin
            exp_tbl = '{7'b1000000, 7'b1100001, 7'b0000000};
            line = {4'hB, 2'b01, 10'h123};
            drive_snoop(2'b01, 2'b10, 4'hB);
         end else begin
            exp_tbl = '{7'b1000000, 7'b1000001, 7'b0000000};
            line = {4'hD, 2'b11, 10'h0F0};
            drive_snoop(2'b10, 2'b10, 4'hD);
         end
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
            checks++;
            if (obs !== exp_tbl[c]) begin failures++; $display("FAIL inval%0d cycle%0d: got %b want %b", k, c + 1, obs, exp_tbl[c]); end
         end
         checks++;
         if (sif.err !== (k == 1)) begin failures++; $display("FAIL inval%0d err: got %b want %b", k, sif.err, (k == 1)); end
      end
   endtask

   task automatic test_reset_mid_wb();
      logic [6:0] exp_tbl [5];
      logic [6:0] obs;
      logic [46:0] v;
      logic [15:0] e;
      exp_tbl = '{7'b1000000, 7'b1000000, 7'b1000100, 7'b1000100, 7'b1000100};
      line = {4'hE, 2'b11, 10'h2AA};
      wb_exp_q.push_back({4'hE, 2'b11, 10'h2AA});
      drive_snoop(2'b01, 2'b00, 4'hE);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== exp_tbl[c]) begin failures++; $display("FAIL rst_wb cycle%0d: got %b want %b", c + 1, obs, exp_tbl[c]); end
         if (c == 2) begin
            checks++;
            e = (wb_exp_q.size() > 0) ? wb_exp_q.pop_front() : 16'hxxxx;
            if (sif.wb_block !== e) begin failures++; $display("FAIL rst_wb wb_block: got %h want %h", sif.wb_block, e); end
         end
      end
      rst_n = 1'b0;
      #1;
      v = {sif.snoop_busy, sif.lkp_tag, sif.upd_en, sif.upd_state, sif.wb_req, sif.wb_block,
           sif.has_block, sif.block_out, sif.done, sif.err, dbg_state};
      checks++;
      if (v !== '0) begin failures++; $display("FAIL rst_wb outputs: got %h want 0", v); end
      @(negedge clk);
      rst_n = 1'b1;
      test_read_hit_e();  // first snoop after reset is accepted normally
   endtask

   task automatic test_wb_stall();
      logic [6:0] obs;
      logic [6:0] want;
      logic [15:0] e;
      line = {4'h6, 2'b11, 10'h2AA};
      wb_exp_q.push_back({4'h6, 2'b11, 10'h2AA});
      sif.wb_ack = 1'b0;
      drive_snoop(2'b01, 2'b01, 4'h6);
`ifdef SNOOP_WB_TIMEOUT_EN
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk);
         if (c <= 2)       want = 7'b1000000;
         else if (c <= 17) want = 7'b1000100;
         else if (c == 18) want = 7'b1100001;
         else              want = 7'b0000000;
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== want) begin failures++; $display("FAIL timeout cycle%0d: got %b want %b", c, obs, want); end
         if (c == 3) begin
            checks++;
            e = (wb_exp_q.size() > 0) ? wb_exp_q.pop_front() : 16'hxxxx;
            if (sif.wb_block !== e) begin failures++; $display("FAIL timeout wb_block: got %h want %h", sif.wb_block, e); end
         end
         if (c == 17 || c == 18) begin
            checks++;
            if (sif.err !== (c == 18)) begin failures++; $display("FAIL timeout err cycle%0d: got %b want %b", c, sif.err, (c == 18)); end
         end
      end
`else
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         want = (c <= 2) ? 7'b1000000 : 7'b1000100;
         obs = {sif.snoop_busy, sif.upd_en, sif.upd_state, sif.wb_req, sif.has_block, sif.done};
         checks++;
         if (obs !== want) begin failures++; $display("FAIL wb_hold cycle%0d: got %b want %b", c, obs, want); end
         if (c == 3) begin
            checks++;
            e = (wb_exp_q.size() > 0) ? wb_exp_q.pop_front() : 16'hxxxx;
            if (sif.wb_block !== e) begin failures++; $display("FAIL wb_hold wb_block: got %h want %h", sif.wb_block, e); end
         end
      end
      checks++;
      if (sif.err !== 1'b0) begin failures++; $display("FAIL wb_hold err: got %b want 0", sif.err); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (sif.wb_req !== 1'b0) begin failures++; $display("FAIL wb_hold reset wb_req: got %b want 0", sif.wb_req); end
      @(negedge clk);
      rst_n = 1'b1;
`endif
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      sif.bus_valid = 1'b0;
      sif.bus = '0;
      sif.wb_ack = 1'b0;
      line = '0;
      line_vld = 1'b0;
      test_reset();
      test_read_hit_e();
      test_write_hit_m();
      test_m_ack_early();
      test_ignored();
      test_miss();
      test_back_to_back();
      test_invalidate();
      test_reset_mid_wb();
      test_wb_stall();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || wb_exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d/%0d left want 0/0", exp_q.size(), wb_exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog against a stalled run
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
